// File: rtl/cast_gain_scheduler.sv
// Block-floating-point caster: wide signed samples to narrow output,
// with the shift for each frame chosen from the peak of the previous one.
module cast_gain_scheduler #(
  parameter int IN_W       = 32,
  parameter int OUT_W      = 16,
  parameter int FRAME_LEN  = 1024,
  parameter int SHIFT_W    = 5,
  parameter int INIT_SHIFT = IN_W - OUT_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               s_valid,
  output logic               s_ready,
  input  logic [IN_W-1:0]    s_data,
  output logic               m_valid,
  input  logic               m_ready,
  output logic [OUT_W-1:0]   m_data,
  output logic               m_last,
  output logic [SHIFT_W-1:0] m_shift,
  output logic               sat_flag,
  input  logic               manual_en,
  input  logic [SHIFT_W-1:0] manual_shift,
  output logic               frame_done
);

  localparam int CNT_W = (FRAME_LEN > 2) ? $clog2(FRAME_LEN) : 1;
  localparam logic [CNT_W-1:0] C_LAST = CNT_W'(FRAME_LEN - 1);
  localparam logic signed [IN_W-1:0] C_MAX =
    IN_W'((64'd1 << (OUT_W - 1)) - 64'd1);
  localparam logic signed [IN_W-1:0] C_MIN = ~C_MAX;
  localparam logic [7:0] C_OUTW8 = 8'(OUT_W);
  localparam logic [7:0] C_MAXS8 = 8'(IN_W - OUT_W);
  localparam logic [SHIFT_W-1:0] C_MAXS = SHIFT_W'(IN_W - OUT_W);

  typedef enum logic {ACC, COMMIT} state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [CNT_W-1:0]   r_cnt;
  logic [IN_W-1:0]    r_peak;
  logic [SHIFT_W-1:0] r_cur_shift;

  logic               r_m_valid;
  logic [OUT_W-1:0]   r_m_data;
  logic               r_m_last;
  logic [SHIFT_W-1:0] r_m_shift;
  logic               r_sat;

  logic               w_s_ready;
  logic               w_commit;
  logic               w_accept;
  logic               w_last;
  logic signed [IN_W-1:0] w_t;
  logic [OUT_W-1:0]   w_cast;
  logic               w_sat;
  logic [IN_W-1:0]    w_mag;
  logic [7:0]         w_needed;
  logic [7:0]         w_auto8;
  logic [SHIFT_W-1:0] w_next_shift;

  assign w_accept = s_valid && w_s_ready;
  assign w_last   = (r_cnt == C_LAST);

  // Arithmetic shift then saturate into OUT_W
  assign w_t = $signed(s_data) >>> r_cur_shift;

  always_comb begin
    w_sat  = 1'b0;
    w_cast = w_t[OUT_W-1:0];
    if (w_t > C_MAX) begin
      w_sat  = 1'b1;
      w_cast = C_MAX[OUT_W-1:0];
    end else if (w_t < C_MIN) begin
      w_sat  = 1'b1;
      w_cast = C_MIN[OUT_W-1:0];
    end
  end

  // Ones'-complement magnitude avoids overflow on the most negative input
  assign w_mag = s_data ^ {IN_W{s_data[IN_W-1]}};

  always_comb begin
    w_needed = 8'd1;
    for (int i = 0; i < IN_W; i++) begin
      if (r_peak[i]) w_needed = 8'(i + 2);
    end
  end

  always_comb begin
    w_auto8 = 8'd0;
    if (w_needed > C_OUTW8) w_auto8 = w_needed - C_OUTW8;
    if (w_auto8 > C_MAXS8) w_auto8 = C_MAXS8;
  end

  always_comb begin
    w_next_shift = SHIFT_W'(w_auto8);
    if (manual_en) begin
      w_next_shift = (manual_shift > C_MAXS) ? C_MAXS : manual_shift;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ACC;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ACC:     if (w_accept && w_last) w_state_nxt = COMMIT;
      COMMIT:  w_state_nxt = ACC;
      default: w_state_nxt = ACC;
    endcase
  end

  always_comb begin
    w_s_ready = 1'b0;
    w_commit  = 1'b0;
    case (r_state)
      ACC:     w_s_ready = !r_m_valid || m_ready;
      COMMIT:  w_commit  = 1'b1;
      default: w_s_ready = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt       <= '0;
      r_peak      <= '0;
      r_cur_shift <= SHIFT_W'(INIT_SHIFT);
    end else if (w_commit) begin
      r_cur_shift <= w_next_shift;
      r_peak      <= '0;
    end else if (w_accept) begin
      r_peak <= r_peak | w_mag;
      r_cnt  <= w_last ? '0 : r_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_m_valid <= 1'b0;
      r_m_data  <= '0;
      r_m_last  <= 1'b0;
      r_m_shift <= '0;
      r_sat     <= 1'b0;
    end else if (w_accept) begin
      r_m_valid <= 1'b1;
      r_m_data  <= w_cast;
      r_m_last  <= w_last;
      r_m_shift <= r_cur_shift;
      r_sat     <= w_sat;
    end else if (m_ready) begin
      r_m_valid <= 1'b0;
    end
  end

  assign s_ready    = w_s_ready;
  assign frame_done = w_commit;
  assign m_valid    = r_m_valid;
  assign m_data     = r_m_data;
  assign m_last     = r_m_last;
  assign m_shift    = r_m_shift;
  assign sat_flag   = r_sat;

endmodule

// File: tb/tb_cast_gain_scheduler.sv
// Scoreboard bench for cast_gain_scheduler, FRAME_LEN=4.
// Expected beats come from a small reference model of the cast/peak rules.
module tb_cast_gain_scheduler;

  logic        clk = 0;
  logic        rst = 1;
  logic        s_valid = 0;
  logic        s_ready;
  logic [31:0] s_data = 0;
  logic        m_valid;
  logic        m_ready = 1;
  logic [15:0] m_data;
  logic        m_last;
  logic [4:0]  m_shift;
  logic        sat_flag;
  logic        manual_en = 0;
  logic [4:0]  manual_shift = 0;
  logic        frame_done;

  int n_chk = 0;
  int n_fail = 0;

  typedef struct {
    logic [15:0] d;
    logic        last;
    logic [4:0]  sh;
    logic        sat;
  } beat_t;

  beat_t       q[$];
  logic [4:0]  mshift = 5'd16;
  logic [31:0] mpeak = 0;
  int          mcnt = 0;

  always #5 clk = ~clk;

  cast_gain_scheduler #(
    .IN_W(32), .OUT_W(16), .FRAME_LEN(4), .SHIFT_W(5), .INIT_SHIFT(16)
  ) dut (
    .clk(clk), .rst(rst),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .m_last(m_last), .m_shift(m_shift), .sat_flag(sat_flag),
    .manual_en(manual_en), .manual_shift(manual_shift),
    .frame_done(frame_done)
  );

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  function automatic beat_t model_cast(input logic [31:0] d,
                                       input logic [4:0] sh);
    beat_t b;
    logic signed [31:0] t;
    t = $signed(d) >>> sh;
    b.sh = sh;
    b.last = 1'b0;
    if (t > 32767) begin
      b.d = 16'h7FFF; b.sat = 1'b1;
    end else if (t < -32768) begin
      b.d = 16'h8000; b.sat = 1'b1;
    end else begin
      b.d = t[15:0]; b.sat = 1'b0;
    end
    return b;
  endfunction

  function automatic logic [4:0] model_next(input logic [31:0] pk);
    int need = 1;
    int a;
    for (int i = 0; i < 32; i++) if (pk[i]) need = i + 2;
    a = (need > 16) ? need - 16 : 0;
    if (a > 16) a = 16;
    if (manual_en) return (manual_shift > 5'd16) ? 5'd16 : manual_shift;
    return 5'(a);
  endfunction

  task automatic model_accept(input logic [31:0] d);
    beat_t b;
    b = model_cast(d, mshift);
    mpeak = mpeak | (d ^ {32{d[31]}});
    if (mcnt == 3) begin
      b.last = 1'b1;
      mcnt = 0;
      mshift = model_next(mpeak);
      mpeak = 0;
    end else begin
      mcnt++;
    end
    q.push_back(b);
  endtask

  task automatic send(input logic [31:0] d);
    int n = 0;
    logic acc = 0;
    s_valid = 1;
    s_data = d;
    while (!acc && n < 100) begin
      @(negedge clk);
      acc = s_ready;
      @(posedge clk);
      #1;
      n++;
    end
    s_valid = 0;
    if (!acc) check("send_timeout", 0, 1);
    else model_accept(d);
  endtask

  always @(negedge clk) begin
    if (!rst && m_valid && m_ready) begin
      if (q.size() == 0) begin
        check("extra_beat", 1, 0);
      end else begin
        beat_t b;
        b = q.pop_front();
        check("beat_data", 32'(m_data), 32'(b.d));
        check("beat_last", 32'(m_last), 32'(b.last));
        check("beat_shift", 32'(m_shift), 32'(b.sh));
        check("beat_sat", 32'(sat_flag), 32'(b.sat));
      end
    end
  end

  initial begin
    #1;
    check("rst_m_valid", 32'(m_valid), 0);
    check("rst_m_data", 32'(m_data), 0);
    check("rst_m_shift", 32'(m_shift), 0);
    check("rst_frame_done", 32'(frame_done), 0);
    repeat (2) @(posedge clk);
    #1 rst = 0;
    check("rst_s_ready", 32'(s_ready), 1);

    // Frame 0: full-scale positive at initial shift 16
    send(32'h7FFFFFFF);
    check("f0_first_data", 32'(m_data), 32'h7FFF);
    check("f0_first_shift", 32'(m_shift), 16);
    check("f0_first_sat", 32'(sat_flag), 0);
    send(0); send(0); send(0);
    check("f0_last", 32'(m_last), 1);
    check("f0_frame_done", 32'(frame_done), 1);
    check("f0_commit_s_ready", 32'(s_ready), 0);
    @(posedge clk); #1;
    check("f0_done_pulse", 32'(frame_done), 0);
    check("f0_ready_back", 32'(s_ready), 1);

    // Frame 1: peak 0x1234 -> next shift 0
    send(32'h00001234); send(32'h10); send(-32'sd5); send(0);
    @(posedge clk); #1;

    // Frame 2: shift 0, saturation both ways
    send(32'h00001234);
    check("f2_shift", 32'(m_shift), 0);
    check("f2_pass", 32'(m_data), 32'h1234);
    send(32'h00010000);
    check("f2_sat_pos", 32'(m_data), 32'h7FFF);
    check("f2_sat_pos_f", 32'(sat_flag), 1);
    send(32'hFFFE0000);
    check("f2_sat_neg", 32'(m_data), 32'h8000);
    check("f2_sat_neg_f", 32'(sat_flag), 1);
    send(0);
    @(posedge clk); #1;

    // Frame 3: contains -0x123456 -> next shift 6
    send(-32'sh123456); send(1); send(2); send(3);
    @(posedge clk); #1;

    // Frame 4: manual override requested during its commit
    send(32'h00123456);
    check("f4_shift", 32'(m_shift), 6);
    check("f4_data", 32'(m_data), 32'h48D1);
    send(5); send(6);
    manual_en = 1;
    manual_shift = 5'd31;
    send(7);
    @(posedge clk); #1;
    manual_en = 0;
    manual_shift = 0;

    // Frame 5: clamped manual shift, small values -> auto 0 next
    send(32'h100);
    check("f5_manual_clamp", 32'(m_shift), 16);
    send(32'h200); send(32'h300); send(32'h7F);
    @(posedge clk); #1;

    // Frame 6: backpressure then reset mid-frame
    send(32'h00000042);
    check("f6_auto_resume", 32'(m_shift), 0);
    m_ready = 0;
    repeat (5) begin
      @(posedge clk); #1;
      check("stall_s_ready", 32'(s_ready), 0);
      check("stall_hold", 32'(m_data), (q.size() > 0) ? 32'(q[0].d) : 32'hDEAD);
    end
    m_ready = 1;
    send(32'h00000043);
    rst = 1;
    #1;
    check("mid_rst_valid", 32'(m_valid), 0);
    check("mid_rst_data", 32'(m_data), 0);
    check("mid_rst_last", 32'(m_last), 0);
    check("mid_rst_sat", 32'(sat_flag), 0);
    q.delete();
    mshift = 5'd16;
    mpeak = 0;
    mcnt = 0;
    @(posedge clk); #1;
    rst = 0;

    // Frame 7: fresh frame after reset
    send(32'h00050000);
    check("f7_shift", 32'(m_shift), 16);
    check("f7_data", 32'(m_data), 32'h0005);
    send(1); send(2);
    check("f7_not_last", 32'(m_last), 0);
    send(3);
    check("f7_last", 32'(m_last), 1);
    check("f7_done", 32'(frame_done), 1);

    repeat (4) @(posedge clk);
    #1;
    check("drain_empty", 32'(q.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
